// File: rtl/bcd_pkg.sv
// Shared definitions for the arbitrated binary-to-BCD converter.
//   bcd_digits()  : number of BCD digits needed for a W-bit binary value
//   bcd_state_t   : converter FSM states
//   BCD_ADD3_*    : double-dabble correction constants
package bcd_pkg;

    // floor(w*log10(2)) + 1 digits cover 0 .. 2^w-1
    function automatic int bcd_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3        = 4'd3;

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble iteration over the {bcd, bin} shift vector.
// Every BCD digit >= 5 is corrected by +3 in parallel, then the whole vector
// shifts left by one bit.
// Ports:
//   i_sr : current {bcd, bin} vector, BCD digits above the low W binary bits
//   o_sr : vector after correction and shift
module bcd_dd_step
    import bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = bcd_digits(16)
) (
    input  logic [4*DIGITS+W-1:0] i_sr,
    output logic [4*DIGITS+W-1:0] o_sr
);

    logic [4*DIGITS+W-1:0] w_corr;

    always_comb begin
        w_corr = i_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_sr[W+4*d +: 4] >= BCD_ADD3_THRESH) begin
                w_corr[W+4*d +: 4] = i_sr[W+4*d +: 4] + BCD_ADD3;
            end
        end
    end

    assign o_sr = w_corr << 1;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one iterative double-dabble binary-to-BCD engine among NUM_REQ
// requesters. One shift per clock; each result is returned tagged with the
// index of the requester that supplied the operand.
//
// Build option: `BCD_FIXED_PRIORITY_EN selects fixed priority (lowest index
// wins, no pointer). Default build is round-robin.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester valid
//   req_data   : packed operands, requester i at [i*W +: W]
//   req_ready  : one-hot grant, only nonzero in IDLE
//   out_valid  : result valid (DONE state)
//   out_ready  : consumer ready
//   out_bcd    : BCD result, units digit in [3:0]
//   out_id     : requester index owning out_bcd
//   busy       : high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | arbitrate; a transfer loads the operand and starts conversion
// SHIFT | one correct-and-shift iteration per cycle, W iterations total
// DONE  | result presented; leaves on out_valid & out_ready
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter  int W       = 16,
    parameter  int NUM_REQ = 4,
    localparam int DIGITS  = bcd_digits(W),
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*W-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    localparam int SR_W  = 4*DIGITS + W;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    bcd_state_t           r_state;
    bcd_state_t           w_state_nxt;
    logic [SR_W-1:0]      r_sr;
    logic [SR_W-1:0]      w_sr_step;
    logic [CNT_W-1:0]     r_cnt;
    logic [ID_W-1:0]      r_id;
    logic [ID_W-1:0]      w_gnt_id;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_gnt_any;
    logic                 w_xfer;
    logic                 w_last_iter;

`ifdef BCD_FIXED_PRIORITY_EN
    // Scan from the top down so the lowest asserted index is assigned last.
    always_comb begin
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_any = 1'b0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_gnt_id   = ID_W'(i);
                w_gnt_any  = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] r_ptr;

    // Walk offsets from farthest to nearest so the first valid requester
    // after the last grant is the one left standing.
    always_comb begin
        int idx;
        idx       = 0;
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_any = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(r_ptr) + off) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grant      = '0;
                w_grant[idx] = 1'b1;
                w_gnt_id     = ID_W'(idx);
                w_gnt_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(NUM_REQ-1);
        end else if (w_xfer) begin
            r_ptr <= w_gnt_id;
        end
    end
`endif

    assign w_xfer      = (r_state == IDLE) && w_gnt_any;
    assign w_last_iter = (r_cnt == CNT_W'(W-1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_xfer)      w_state_nxt = SHIFT;
            SHIFT:   if (w_last_iter) w_state_nxt = DONE;
            DONE:    if (out_ready)   w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    bcd_dd_step #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_step (
        .i_sr (r_sr),
        .o_sr (w_sr_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_id  <= '0;
        end else begin
            if (w_xfer) begin
                r_sr  <= SR_W'(req_data[int'(w_gnt_id)*W +: W]);
                r_id  <= w_gnt_id;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_sr  <= w_sr_step;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_bcd   = r_sr[SR_W-1 -: 4*DIGITS];
    assign out_id    = r_id;

endmodule
